datapath_sequencer: RTL and testbench

- Multi-cycle control FSM replacing the manual VIO control of the ALU / register file / data memory datapath.
- Accepts one 16-bit instruction per valid/ready handshake, decodes it, and drives the datapath control signals through EXEC, MEM and WB phases.
- Outputs connect directly to the regfile write enable, source/destination addresses, ALUSrc1/ALUSrc2 mux selects, ALUOp, MemWrite, MemToReg and the immediate input of the ALU-B mux.
- Reports branch, overflow and illegal-opcode events.

---
 rtl/datapath_sequencer_if.sv | 40 ++++
 rtl/datapath_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake and datapath control bundle for datapath_sequencer.
// master = instruction source / datapath side, slave = the sequencer.
interface datapath_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        alu_ovf;
    logic        alu_take_branch;
    logic        reg_write;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic [2:0]  wr_addr;
    logic        alu_src1;
    logic        alu_src2;
    logic [15:0] imm_out;
    logic [3:0]  alu_op;
    logic        mem_write;
    logic        mem_to_reg;
    logic        busy;
    logic        done;
    logic        branch_taken;
    logic        ovf_trap;
    logic        illegal_op;

    modport master (
        output instr_valid, instr, alu_ovf, alu_take_branch,
        input  instr_ready, reg_write, rd_addr1, rd_addr2, wr_addr,
        input  alu_src1, alu_src2, imm_out, alu_op, mem_write,
        input  mem_to_reg, busy, done, branch_taken, ovf_trap,
        input  illegal_op
    );

    modport slave (
        input  instr_valid, instr, alu_ovf, alu_take_branch,
        output instr_ready, reg_write, rd_addr1, rd_addr2, wr_addr,
        output alu_src1, alu_src2, imm_out, alu_op, mem_write,
        output mem_to_reg, busy, done, branch_taken, ovf_trap,
        output illegal_op
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the ALU / regfile / data memory datapath.
// One 16-bit instruction per handshake, sequenced DECODE-EXEC-MEM-WB.
module datapath_sequencer #(
    parameter logic [3:0] ALU_ADD  = 4'h0,
    parameter logic [3:0] ALU_BEQ  = 4'h8,
    parameter bit         OVF_TRAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    datapath_sequencer_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0]  rd1_q, rd1_d;
    logic [2:0]  rd2_q, rd2_d;
    logic [2:0]  wra_q, wra_d;
    logic        src1_q, src1_d;
    logic        src2_q, src2_d;
    logic [15:0] imm_q, imm_d;
    logic [3:0]  aop_q, aop_d;
    logic        m2r_q, m2r_d;

    logic [3:0]  op;
    logic [2:0]  f_rs, f_rt, f_rd;
    logic [15:0] imm6_sx, imm9_sx;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_li, is_ill;

    logic        in_decode, in_exec, in_mem, in_wb;
    logic        trap_hit;

    // IR field extraction; the IR holds the instruction for its whole life
    assign op      = ir_q[15:12];
    assign f_rs    = ir_q[11:9];
    assign f_rt    = ir_q[8:6];
    assign f_rd    = ir_q[5:3];
    assign imm6_sx = {{10{ir_q[5]}}, ir_q[5:0]};
    assign imm9_sx = {{7{ir_q[8]}}, ir_q[8:0]};

    // Opcode class flags
    always_comb begin
        is_r    = ~op[3];
        is_addi = (op == 4'h8);
        is_lw   = (op == 4'h9);
        is_sw   = (op == 4'hA);
        is_beq  = (op == 4'hB);
        is_li   = (op == 4'hC);
        is_ill  = (op >= 4'hD);
    end

    // Next-state and instruction latch
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = is_ill ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                state_d = is_sw ? S_IDLE : S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control register load at the end of DECODE; held otherwise,
    // so the controls stay put through IDLE until the next legal op
    always_comb begin
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        wra_d  = wra_q;
        src1_d = src1_q;
        src2_d = src2_q;
        imm_d  = imm_q;
        aop_d  = aop_q;
        m2r_d  = m2r_q;
        if (state_q == S_DECODE && !is_ill) begin
            rd1_d  = f_rs;
            rd2_d  = f_rt;
            wra_d  = f_rt;
            src1_d = 1'b0;
            src2_d = 1'b1;
            imm_d  = imm6_sx;
            aop_d  = ALU_ADD;
            m2r_d  = 1'b0;
            unique case (1'b1)
                is_r: begin
                    wra_d  = f_rd;
                    src2_d = 1'b0;
                    aop_d  = {1'b0, op[2:0]};
                end
                is_addi: begin
                end
                is_lw: begin
                    m2r_d = 1'b1;
                end
                is_sw: begin
                end
                is_beq: begin
                    src2_d = 1'b0;
                    aop_d  = ALU_BEQ;
                end
                is_li: begin
                    wra_d  = f_rs;
                    src1_d = 1'b1;
                    imm_d  = imm9_sx;
                end
                default: begin
                end
            endcase
        end
    end

    // State, IR and control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            wra_q   <= '0;
            src1_q  <= 1'b0;
            src2_q  <= 1'b0;
            imm_q   <= '0;
            aop_q   <= '0;
            m2r_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            wra_q   <= wra_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            imm_q   <= imm_d;
            aop_q   <= aop_d;
            m2r_q   <= m2r_d;
        end
    end

    assign in_decode = (state_q == S_DECODE);
    assign in_exec   = (state_q == S_EXEC);
    assign in_mem    = (state_q == S_MEM);
    assign in_wb     = (state_q == S_WB);

    // Overflow only blocks arithmetic writeback; loads and LI ignore it
    assign trap_hit = OVF_TRAP && bus.alu_ovf && (is_r || is_addi);

    // Event pulses decoded from the current phase
    always_comb begin
        bus.illegal_op   = in_decode && is_ill;
        bus.branch_taken = in_exec && is_beq && bus.alu_take_branch;
        bus.mem_write    = in_mem && is_sw;
        bus.reg_write    = in_wb && !trap_hit;
        bus.ovf_trap     = in_wb && trap_hit;
        bus.done         = (in_decode && is_ill) ||
                           (in_exec && is_beq) ||
                           (in_mem && is_sw) ||
                           in_wb;
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.rd_addr1    = rd1_q;
    assign bus.rd_addr2    = rd2_q;
    assign bus.wr_addr     = wra_q;
    assign bus.alu_src1    = src1_q;
    assign bus.alu_src2    = src2_q;
    assign bus.imm_out     = imm_q;
    assign bus.alu_op      = aop_q;
    assign bus.mem_to_reg  = m2r_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: latency-table model,
// per-cycle compare, directed pins and randomized traffic.
module tb_datapath_sequencer;

    localparam bit TRAP = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b0;

    datapath_sequencer_if bus();

    datapath_sequencer #(
        .ALU_ADD (4'h0),
        .ALU_BEQ (4'h8),
        .OVF_TRAP(TRAP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          m_k = 0;
    int          m_acc = 0;
    logic [15:0] m_ir = '0;
    logic [15:0] m_cir = '0;
    bit          m_have = 1'b0;
    bit          rand_alu = 1'b0;

    // Cycles from accept edge to the done cycle
    function automatic int lat(input logic [15:0] w);
        int o;
        o = int'(w[15:12]);
        if (o >= 13) return 1;
        if (o == 11) return 2;
        if (o == 9)  return 4;
        return 3;
    endfunction

    function automatic logic [15:0] sx(input int v);
        return v[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: position within the current instruction (0 = idle)
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k    <= 0;
            m_ir   <= '0;
            m_have <= 1'b0;
            m_cir  <= '0;
        end else if (m_k == 0) begin
            if (bus.instr_valid === 1'b1) begin
                m_k   <= 1;
                m_ir  <= bus.instr;
                m_acc <= m_acc + 1;
            end
        end else if (m_k == lat(m_ir)) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_k == 1) begin
                m_have <= 1'b1;
                m_cir  <= m_ir;
            end
        end
    end

    task automatic compare_all();
        logic [3:0] o, co;
        logic [2:0] rs, rt, rd;
        bit r, lw, sw, beq, ill, wp, trap;
        bit cr, caddi, clw, csw, cbeq, cli;
        int s6, s9;
        o   = m_ir[15:12];
        r   = !o[3];
        lw  = (o == 4'h9);
        sw  = (o == 4'hA);
        beq = (o == 4'hB);
        ill = (o >= 4'hD);
        chk("instr_ready", 32'(bus.instr_ready), 32'(m_k == 0));
        chk("busy", 32'(bus.busy), 32'(m_k != 0));
        chk("done", 32'(bus.done), 32'(m_k != 0 && m_k == lat(m_ir)));
        chk("illegal_op", 32'(bus.illegal_op), 32'(ill && m_k == 1));
        chk("branch_taken", 32'(bus.branch_taken),
            32'(beq && m_k == 2 && bus.alu_take_branch));
        chk("mem_write", 32'(bus.mem_write), 32'(sw && m_k == 3));
        wp   = ((r || o == 4'h8 || o == 4'hC) && m_k == 3) ||
               (lw && m_k == 4);
        trap = TRAP && bus.alu_ovf && (r || o == 4'h8);
        chk("reg_write", 32'(bus.reg_write), 32'(wp && !trap));
        chk("ovf_trap", 32'(bus.ovf_trap), 32'(wp && trap));
        if (!m_have) begin
            chk("ctl_rst", {bus.rd_addr1, bus.rd_addr2, bus.wr_addr,
                bus.alu_src1, bus.alu_src2, bus.alu_op, bus.mem_to_reg},
                32'h0);
            chk("imm_rst", 32'(bus.imm_out), 32'h0);
        end else begin
            co    = m_cir[15:12];
            rs    = m_cir[11:9];
            rt    = m_cir[8:6];
            rd    = m_cir[5:3];
            s6    = $signed(m_cir[5:0]);
            s9    = $signed(m_cir[8:0]);
            cr    = !co[3];
            caddi = (co == 4'h8);
            clw   = (co == 4'h9);
            csw   = (co == 4'hA);
            cbeq  = (co == 4'hB);
            cli   = (co == 4'hC);
            chk("alu_src1", 32'(bus.alu_src1), 32'(cli));
            chk("alu_src2", 32'(bus.alu_src2), 32'(!(cr || cbeq)));
            if (!cli)
                chk("rd_addr1", 32'(bus.rd_addr1), 32'(rs));
            if (cr || csw || cbeq)
                chk("rd_addr2", 32'(bus.rd_addr2), 32'(rt));
            if (cr)
                chk("wr_addr", 32'(bus.wr_addr), 32'(rd));
            if (caddi || clw)
                chk("wr_addr", 32'(bus.wr_addr), 32'(rt));
            if (cli)
                chk("wr_addr", 32'(bus.wr_addr), 32'(rs));
            if (cr)
                chk("alu_op", 32'(bus.alu_op), 32'(co & 4'h7));
            else if (cbeq)
                chk("alu_op", 32'(bus.alu_op), 32'h8);
            else
                chk("alu_op", 32'(bus.alu_op), 32'h0);
            if (caddi || clw || csw)
                chk("imm_out", 32'(bus.imm_out), 32'(sx(s6)));
            if (cli)
                chk("imm_out", 32'(bus.imm_out), 32'(sx(s9)));
            if (!csw && !cbeq)
                chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(clw));
        end
    endtask

    always @(negedge clk) compare_all();

    // ALU status inputs, randomized during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_alu) begin
                bus.alu_ovf         = 1'($urandom_range(0, 1));
                bus.alu_take_branch = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue(input logic [15:0] w, input bit hold);
        int a0;
        bit got;
        a0  = m_acc;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (m_acc != a0) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept", 32'(got), 32'h1);
        if (!hold)
            bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (m_k == 0) break;
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", 32'(m_k == 0), 32'h1);
    endtask

    initial begin
        bus.instr_valid     = 1'b0;
        bus.instr           = '0;
        bus.alu_ovf         = 1'b0;
        bus.alu_take_branch = 1'b0;
        #1 reset = 1'b1;
        #20 reset = 1'b0;
        @(negedge clk);
        chk("pin_rst_ready", 32'(bus.instr_ready), 32'h1);
        chk("pin_rst_wr", 32'(bus.reg_write), 32'h0);

        // LI rd=1, imm9=0x1F5
        issue(16'hC3F5, 1'b0);
        @(negedge clk);
        chk("pin_li_ready_c1", 32'(bus.instr_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("pin_li_wr_addr", 32'(bus.wr_addr), 32'h1);
        chk("pin_li_imm", 32'(bus.imm_out), 32'hFFF5);
        chk("pin_li_src", {bus.alu_src1, bus.alu_src2}, 32'h3);
        chk("pin_li_rw", {bus.reg_write, bus.done}, 32'h3);
        wait_idle();

        // R-type op=2 with valid held high across two accepts
        issue(16'h2298, 1'b1);
        repeat (3) @(negedge clk);
        chk("pin_r_addrs", {bus.rd_addr1, bus.rd_addr2, bus.wr_addr},
            32'h053);
        chk("pin_r_op", 32'(bus.alu_op), 32'h2);
        chk("pin_r_rw", 32'(bus.reg_write), 32'h1);
        issue(16'h2298, 1'b0);
        wait_idle();

        // SW then LW
        issue(16'hA0BF, 1'b0);
        repeat (3) @(negedge clk);
        chk("pin_sw_mw", {bus.mem_write, bus.reg_write, bus.done}, 32'h5);
        chk("pin_sw_imm", 32'(bus.imm_out), 32'hFFFF);
        wait_idle();
        issue(16'h913F, 1'b0);
        repeat (4) @(negedge clk);
        chk("pin_lw_rw", {bus.reg_write, bus.mem_to_reg, bus.done},
            32'h7);
        chk("pin_lw_wr", 32'(bus.wr_addr), 32'h4);
        wait_idle();

        // BEQ taken, then not taken
        bus.alu_take_branch = 1'b1;
        issue(16'hB080, 1'b0);
        repeat (2) @(negedge clk);
        chk("pin_beq_t", {bus.branch_taken, bus.done}, 32'h3);
        chk("pin_beq_op", 32'(bus.alu_op), 32'h8);
        wait_idle();
        bus.alu_take_branch = 1'b0;
        issue(16'hB080, 1'b0);
        repeat (2) @(negedge clk);
        chk("pin_beq_nt", {bus.branch_taken, bus.done}, 32'h1);
        wait_idle();

        // ADDI with overflow in WB
        bus.alu_ovf = 1'b1;
        issue(16'h8285, 1'b0);
        repeat (3) @(negedge clk);
        chk("pin_addi_trap", {bus.reg_write, bus.ovf_trap, bus.done},
            32'h3);
        wait_idle();
        bus.alu_ovf = 1'b0;

        // Illegal opcode
        issue(16'hE000, 1'b0);
        @(negedge clk);
        chk("pin_ill", {bus.illegal_op, bus.done, bus.reg_write}, 32'h6);
        wait_idle();

        // Reset during the EXEC cycle of an LW
        issue(16'h913F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("pin_rst_mid", {bus.instr_ready, bus.done, bus.mem_write,
            bus.reg_write, bus.busy}, 32'h10);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("pin_post_rst", {bus.instr_ready, bus.reg_write,
                bus.done}, 32'h4);
        end

        // Randomized traffic with sporadic resets
        rand_alu = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.instr       = 16'($urandom);
            reset           = ($urandom_range(0, 249) == 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.instr_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
